// File: rtl/line_window_3x3_gen.sv
`default_nettype none
// ============================================================================
// line_window_3x3_gen : three-line buffer emitting 3x3 windows + edge flags
// Rev 1.0
// ============================================================================
module line_window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 640,
  parameter int CNT_W = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [105:0] out_win,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         frame_done
);

  localparam int AW = $clog2(IMG_W);
  localparam int SW = $clog2(IMG_W + 1);
  localparam int PW = $clog2(IMG_H);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR     = AW'(IMG_W - 1);
  localparam logic [SW-1:0] LAST_STEP     = SW'(IMG_W - 1);
  localparam logic [SW-1:0] STEP_END      = SW'(IMG_W);
  localparam logic [PW-1:0] LAST_PASS     = PW'(IMG_H - 1);
  localparam logic [PW-1:0] PRE_LAST_PASS = PW'(IMG_H - 2);

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [1:0]    fsel_q, fsel_d;
  logic [1:0]    top_q, top_d;
  logic [SW-1:0] step_q, step_d;
  logic [PW-1:0] pass_q, pass_d;
  logic [105:0]  out_win_q, out_win_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [7:0] lb_mem [3][IMG_W];

  logic          pix_xfer, can_load, last_xfer;
  logic [1:0]    wr_sel, mid_sel, bot_sel;
  logic [AW-1:0] col_idx;
  logic [PW-1:0] row_idx;
  logic          zr, fr, zc, fc;
  logic [23:0]   top_line, mid_line, bot_line;
  logic [105:0]  win;

  always_comb begin
    pix_ready = ((state_q == S_FILL) || (state_q == S_LOAD)) && !reset;
    pix_xfer  = pix_valid && pix_ready;
    can_load  = !out_valid_q || out_ready;
    last_xfer = out_valid_q && out_ready && out_win_q[72];
    wr_sel    = (state_q == S_FILL) ? fsel_q : top_q;
    mid_sel   = inc3(top_q);
    bot_sel   = inc3(mid_sel);
  end

  // Step/pass index maps onto col/row with the edge position duplicated at both ends.
  always_comb begin
    if (step_q == '0)            col_idx = '0;
    else if (step_q == LAST_STEP) col_idx = AW'(IMG_W - 3);
    else                          col_idx = AW'(step_q - SW'(1));
    if (pass_q == '0)             row_idx = '0;
    else if (pass_q == LAST_PASS) row_idx = PW'(IMG_H - 3);
    else                          row_idx = pass_q - PW'(1);
    zc = (step_q != '0);
    fc = (step_q == LAST_STEP);
    zr = (pass_q != '0);
    fr = (pass_q == LAST_PASS);
    top_line = '0;
    mid_line = '0;
    bot_line = '0;
    for (int k = 0; k < 3; k++) begin
      top_line[23-8*k -: 8] = lb_mem[top_q][col_idx + AW'(k)];
      mid_line[23-8*k -: 8] = lb_mem[mid_sel][col_idx + AW'(k)];
      bot_line[23-8*k -: 8] = lb_mem[bot_sel][col_idx + AW'(k)];
    end
    win = {CNT_W'(row_idx), CNT_W'(col_idx), zr, fr, zc, fc, top_line, mid_line, bot_line};
  end

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    fsel_d       = fsel_q;
    top_d        = top_q;
    step_d       = step_q;
    pass_d       = pass_q;
    out_win_d    = out_win_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_FILL: begin
        if (pix_xfer) begin
          if (waddr_q == LAST_ADDR) begin
            waddr_d = '0;
            if (fsel_q == 2'd2) begin
              fsel_d  = 2'd0;
              state_d = S_SWEEP;
            end else begin
              fsel_d = fsel_q + 2'd1;
            end
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      S_SWEEP: begin
        if (can_load) begin
          if (step_q != STEP_END) begin
            out_win_d   = win;
            out_valid_d = 1'b1;
            step_d      = step_q + SW'(1);
          end else begin
            out_valid_d = 1'b0;
          end
        end
        // Pass ends when the final_col window leaves the output register.
        if (last_xfer) begin
          step_d = '0;
          if (pass_q == LAST_PASS) begin
            state_d      = S_FILL;
            pass_d       = '0;
            top_d        = 2'd0;
            frame_done_d = 1'b1;
          end else begin
            pass_d = pass_q + PW'(1);
            if ((pass_q != '0) && (pass_q != PRE_LAST_PASS)) state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (pix_xfer) begin
          if (waddr_q == LAST_ADDR) begin
            waddr_d = '0;
            top_d   = inc3(top_q);
            state_d = S_SWEEP;
          end else begin
            waddr_d = waddr_q + AW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FILL;
      waddr_q      <= '0;
      fsel_q       <= 2'd0;
      top_q        <= 2'd0;
      step_q       <= '0;
      pass_q       <= '0;
      out_win_q    <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      fsel_q       <= fsel_d;
      top_q        <= top_d;
      step_q       <= step_d;
      pass_q       <= pass_d;
      out_win_q    <= out_win_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_xfer) lb_mem[wr_sel][waddr_q] <= pix_in;
  end

  assign out_win    = out_win_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
